hazard_ctrl: RTL and testbench

//  Hazard controller for the 5-stage MIPS pipeline; sits beside Control_Unit and the datapath.

---
 rtl/hazard_pkg.sv | 36 +++
 rtl/md_sequencer.sv | 61 ++++++
 rtl/hazard_ctrl.sv | 84 ++++++++
 tb/tb_hazard_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
package hazard_pkg;

  // E-stage ALU operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Mul/div sequencer state encodings
  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_BUSY = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  typedef enum logic [1:0] {
    MdIdle = MD_IDLE,
    MdBusy = MD_BUSY,
    MdDone = MD_DONE
  } md_state_e;

  // E-stage operand select: M result beats W result; $0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       reg_write_m,
                                         input logic [4:0] write_reg_m,
                                         input logic       reg_write_w,
                                         input logic [4:0] write_reg_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != 5'd0 && reg_write_m && write_reg_m == src) begin
      sel = FWD_MEM;
    end else if (src != 5'd0 && reg_write_w && write_reg_w == src) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/md_sequencer.sv
// Latency sequencer for the multi-cycle mul/div unit: counts the busy window and
// raises a one-cycle HI/LO write at its end.
module md_sequencer
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic busy,
  output logic done,
  output logic active
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MdIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: load LAT-1 so BUSY lasts exactly LAT cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MdIdle: begin
        if (start) begin
          cnt_d   = div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
          state_d = MdBusy;
        end
      end
      MdBusy: begin
        if (cnt_q == '0) begin
          state_d = MdDone;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MdDone:  state_d = MdIdle;
      default: state_d = MdIdle;
    endcase
  end

  // Outputs decode registered state only.
  assign busy   = (state_q == MdBusy) || (state_q == MdDone);
  assign done   = (state_q == MdDone);
  assign active = (state_q != MdIdle);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding selects, load-use,
// branch and mul/div stalls, and IF/ID / ID/EX flushes.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] write_reg_e,
  input  logic [4:0] write_reg_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_e,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       mem_to_reg_e,
  input  logic       mem_to_reg_m,
  input  logic       branch_d,
  input  logic       pc_src_d,
  input  logic       jump_d,
  input  logic       md_start_e,
  input  logic       md_div_e,
  input  logic       md_read_d,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e,
  output logic       fwd_a_d,
  output logic       fwd_b_d,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic       md_busy,
  output logic       md_done
);

  logic md_active;
  logic lw_stall, br_stall, md_stall, stall;

  md_sequencer #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .CNT_W  (CNT_W)
  ) u_md_sequencer (
    .clk   (clk),
    .reset (reset),
    .start (md_start_e),
    .div   (md_div_e),
    .busy  (md_busy),
    .done  (md_done),
    .active(md_active)
  );

  // Stall/flush/forward decode; everything held low while reset is asserted.
  always_comb begin
    lw_stall = mem_to_reg_e && (write_reg_e == rs_d || write_reg_e == rt_d);
    br_stall = branch_d &&
               ((reg_write_e && (write_reg_e == rs_d || write_reg_e == rt_d)) ||
                (mem_to_reg_m && (write_reg_m == rs_d || write_reg_m == rt_d)));
    // A start in E must also hold an HI/LO reader in D, before the FSM leaves IDLE.
    md_stall = md_read_d && (md_active || md_start_e);
    stall    = reset && (lw_stall || br_stall || md_stall);

    stall_f = stall;
    stall_d = stall;
    flush_e = stall;
    flush_d = reset && (pc_src_d || jump_d) && !stall;

    fwd_a_d = reset && (rs_d != 5'd0) && reg_write_m && (write_reg_m == rs_d);
    fwd_b_d = reset && (rt_d != 5'd0) && reg_write_m && (write_reg_m == rt_d);
    fwd_a_e = FWD_RF;
    fwd_b_e = FWD_RF;
    if (reset) begin
      fwd_a_e = fwd_sel(rs_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);
      fwd_b_e = fwd_sel(rt_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
  logic       branch_d, pc_src_d, jump_d, md_start_e, md_div_e, md_read_d;
  logic       stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       md_busy, md_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MUL_LAT(4),
    .DIV_LAT(32),
    .CNT_W  (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rs_d        (rs_d),
    .rt_d        (rt_d),
    .rs_e        (rs_e),
    .rt_e        (rt_e),
    .write_reg_e (write_reg_e),
    .write_reg_m (write_reg_m),
    .write_reg_w (write_reg_w),
    .reg_write_e (reg_write_e),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .mem_to_reg_e(mem_to_reg_e),
    .mem_to_reg_m(mem_to_reg_m),
    .branch_d    (branch_d),
    .pc_src_d    (pc_src_d),
    .jump_d      (jump_d),
    .md_start_e  (md_start_e),
    .md_div_e    (md_div_e),
    .md_read_d   (md_read_d),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .flush_e     (flush_e),
    .fwd_a_d     (fwd_a_d),
    .fwd_b_d     (fwd_b_d),
    .fwd_a_e     (fwd_a_e),
    .fwd_b_e     (fwd_b_e),
    .md_busy     (md_busy),
    .md_done     (md_done)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stall trio packed as {stall_f, stall_d, flush_e}
  function automatic logic [7:0] stalls();
    return {5'd0, stall_f, stall_d, flush_e};
  endfunction

  task automatic clear_inputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
    mem_to_reg_e = 0; mem_to_reg_m = 0;
    branch_d = 0; pc_src_d = 0; jump_d = 0;
    md_start_e = 0; md_div_e = 0; md_read_d = 0;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    // Reset: outputs forced low even with a forwarding match present.
    rs_e = 5'd3; reg_write_m = 1'b1; write_reg_m = 5'd3;
    #1;
    check("rst_fwd_a_e", {6'd0, fwd_a_e}, 8'h0);
    check("rst_busy", {7'd0, md_busy}, 8'h0);
    check("rst_done", {7'd0, md_done}, 8'h0);
    step();
    step();
    reset = 1'b1;
    #1;

    // 1. Forwarding priority and $0.
    check("fwd_m", {6'd0, fwd_a_e}, 8'h2);
    reg_write_w = 1'b1; write_reg_w = 5'd3; #1;
    check("fwd_m_beats_w", {6'd0, fwd_a_e}, 8'h2);
    reg_write_m = 1'b0; #1;
    check("fwd_w", {6'd0, fwd_a_e}, 8'h1);
    rt_e = 5'd3; #1;
    check("fwd_b_w", {6'd0, fwd_b_e}, 8'h1);
    clear_inputs();
    reg_write_m = 1'b1; write_reg_m = 5'd0; rs_e = 5'd0; rs_d = 5'd0; #1;
    check("fwd_zero_e", {6'd0, fwd_a_e}, 8'h0);
    check("fwd_zero_d", {7'd0, fwd_a_d}, 8'h0);
    check("idle_stalls", stalls(), 8'h0);

    // 2. Load-use: lw $5 in E, D reads $5 as rt.
    step();
    clear_inputs();
    mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd5; rt_d = 5'd5; #1;
    check("lw_stall", stalls(), 8'h7);
    check("lw_no_flush_d", {7'd0, flush_d}, 8'h0);
    step();
    // Bubble in M, load now in W, consumer in E.
    clear_inputs();
    rt_e = 5'd5; reg_write_w = 1'b1; write_reg_w = 5'd5; #1;
    check("lw_fwd_b_e", {6'd0, fwd_b_e}, 8'h1);
    check("lw_released", stalls(), 8'h0);

    // 3. Branch hazards.
    step();
    clear_inputs();
    branch_d = 1'b1; rs_d = 5'd2; reg_write_e = 1'b1; write_reg_e = 5'd2; pc_src_d = 1'b1; #1;
    check("br_stall_e", stalls(), 8'h7);
    check("stall_beats_flush", {7'd0, flush_d}, 8'h0);
    step();
    clear_inputs();
    branch_d = 1'b1; rs_d = 5'd2; reg_write_m = 1'b1; write_reg_m = 5'd2; #1;
    check("br_released", stalls(), 8'h0);
    check("br_fwd_a_d", {7'd0, fwd_a_d}, 8'h1);
    check("br_fwd_b_d", {7'd0, fwd_b_d}, 8'h0);
    pc_src_d = 1'b1; #1;
    check("br_flush_d", {7'd0, flush_d}, 8'h1);
    clear_inputs();
    branch_d = 1'b1; rt_d = 5'd9; mem_to_reg_m = 1'b1; write_reg_m = 5'd9; #1;
    check("br_stall_lw_m", stalls(), 8'h7);
    clear_inputs();
    jump_d = 1'b1; #1;
    check("jump_flush_d", {7'd0, flush_d}, 8'h1);

    // 4. Multiply with mfhi waiting in D; start at cycle 0.
    step();
    clear_inputs();
    md_start_e = 1'b1; md_div_e = 1'b0; md_read_d = 1'b1; #1;
    check("mul_c0_stall", stalls(), 8'h7);
    check("mul_c0_busy", {7'd0, md_busy}, 8'h0);
    for (int c = 1; c <= 6; c++) begin
      step();
      md_start_e = 1'b0; #1;
      check($sformatf("mul_c%0d_busy", c), {7'd0, md_busy}, {7'd0, c <= 5});
      check($sformatf("mul_c%0d_done", c), {7'd0, md_done}, {7'd0, c == 5});
      check($sformatf("mul_c%0d_stall", c), stalls(), (c <= 5) ? 8'h7 : 8'h0);
    end

    // Divide: done at cycle 33, idle at 34.
    step();
    clear_inputs();
    md_start_e = 1'b1; md_div_e = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      step();
      md_start_e = 1'b0; md_div_e = 1'b0; #1;
      if (c == 1 || c >= 32) begin
        check($sformatf("div_c%0d_busy", c), {7'd0, md_busy}, {7'd0, c <= 33});
      end
      check($sformatf("div_c%0d_done", c), {7'd0, md_done}, {7'd0, c == 33});
    end

    // 5. Divide aborted by reset while BUSY with cnt=10 (cycle 22).
    step();
    md_start_e = 1'b1; md_div_e = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      step();
      md_start_e = 1'b0; md_div_e = 1'b0;
    end
    #1;
    check("abort_pre_busy", {7'd0, md_busy}, 8'h1);
    reset = 1'b0;
    md_read_d = 1'b1; jump_d = 1'b1; rs_d = 5'd4; reg_write_m = 1'b1; write_reg_m = 5'd4; #1;
    check("abort_busy", {7'd0, md_busy}, 8'h0);
    check("abort_stalls", stalls(), 8'h0);
    check("abort_flush_d", {7'd0, flush_d}, 8'h0);
    check("abort_fwd_a_d", {7'd0, fwd_a_d}, 8'h0);
    step();
    #2;
    reset = 1'b1;
    clear_inputs();
    for (int c = 0; c < 14; c++) begin
      step();
      check($sformatf("post_rst_%0d", c),
            {md_busy, md_done, flush_d, fwd_a_d, fwd_a_e, fwd_b_e}, 8'h0);
    end
    check("post_rst_stalls", stalls(), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
